// File: rtl/overload_error_tx_pkg.sv
// Shared CAN bit levels, default frame lengths and the error/overload TX state encoding.
// The lengths are also used by the overload receiver.
package overload_error_tx_pkg;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    localparam int unsigned DEF_FLAG_LEN    = 6;
    localparam int unsigned DEF_DELIM_LEN   = 8;
    localparam int unsigned DEF_DOM_OVF_LEN = 8;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLAG     = 2'd1,
        ST_WAIT_REC = 2'd2,
        ST_DELIM    = 2'd3
    } tx_state_e;

endpackage

// File: rtl/overload_error_tx.sv
// CAN error/overload frame transmitter: flag, wait for flag superposition to end, recessive delimiter.
// Clocked once per bit by samplePoint; every output is registered.
module overload_error_tx
    import overload_error_tx_pkg::*;
#(
    parameter int unsigned FLAG_LEN    = DEF_FLAG_LEN,
    parameter int unsigned DELIM_LEN   = DEF_DELIM_LEN,
    parameter int unsigned DOM_OVF_LEN = DEF_DOM_OVF_LEN
) (
    input  logic samplePoint,
    input  logic reset,
    input  logic canRX,
    input  logic startOverload,
    input  logic startError,
    input  logic errorPassive,
    output logic canTX,
    output logic busy,
    output logic isErrorFrame,
    output logic endFrame,
    output logic bitError,
    output logic dominantOverflow
);

    localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_LEN - 1);
    localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_LEN - 1);
    localparam logic [CNT_W-1:0] OVF_LAST   = CNT_W'(DOM_OVF_LEN - 1);

    tx_state_e        r_state, w_nxt_state;
    logic [CNT_W-1:0] r_bit_cnt, w_nxt_bit_cnt;
    logic [CNT_W-1:0] r_dom_cnt, w_nxt_dom_cnt;
    logic             r_passive, w_nxt_passive;
    logic             r_tx, w_nxt_tx;
    logic             r_busy;
    logic             r_is_err, w_nxt_is_err;
    logic             r_end, w_nxt_end;
    logic             r_bit_err, w_nxt_bit_err;
    logic             r_ovf, w_nxt_ovf;

    always_ff @(posedge samplePoint or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_dom_cnt <= '0;
            r_passive <= 1'b0;
            r_tx      <= RECESSIVE;
            r_busy    <= 1'b0;
            r_is_err  <= 1'b0;
            r_end     <= 1'b0;
            r_bit_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_bit_cnt <= w_nxt_bit_cnt;
            r_dom_cnt <= w_nxt_dom_cnt;
            r_passive <= w_nxt_passive;
            r_tx      <= w_nxt_tx;
            r_busy    <= (w_nxt_state != ST_IDLE);
            r_is_err  <= w_nxt_is_err;
            r_end     <= w_nxt_end;
            r_bit_err <= w_nxt_bit_err;
            r_ovf     <= w_nxt_ovf;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_bit_cnt = r_bit_cnt;
        w_nxt_dom_cnt = r_dom_cnt;
        w_nxt_passive = r_passive;
        w_nxt_is_err  = r_is_err;
        w_nxt_tx      = RECESSIVE;
        w_nxt_end     = 1'b0;
        w_nxt_bit_err = 1'b0;
        w_nxt_ovf     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (startError) begin
                    w_nxt_state   = ST_FLAG;
                    w_nxt_is_err  = 1'b1;
                    w_nxt_passive = errorPassive;
                    w_nxt_tx      = errorPassive ? RECESSIVE : DOMINANT;
                    w_nxt_bit_cnt = '0;
                end else if (startOverload) begin
                    w_nxt_state   = ST_FLAG;
                    w_nxt_is_err  = 1'b0;
                    w_nxt_passive = 1'b0;
                    w_nxt_tx      = DOMINANT;
                    w_nxt_bit_cnt = '0;
                end
            end
            ST_FLAG: begin
                // A passive flag is recessive and is overwritten freely, so it never flags errors.
                w_nxt_tx      = r_passive ? RECESSIVE : DOMINANT;
                w_nxt_bit_err = !r_passive && (canRX == RECESSIVE);
                if (r_bit_cnt == FLAG_LAST) begin
                    w_nxt_state   = ST_WAIT_REC;
                    w_nxt_tx      = RECESSIVE;
                    w_nxt_bit_cnt = '0;
                    w_nxt_dom_cnt = '0;
                end else begin
                    w_nxt_bit_cnt = r_bit_cnt + 1'b1;
                end
            end
            ST_WAIT_REC: begin
                if (canRX == DOMINANT) begin
                    if (r_dom_cnt == OVF_LAST) begin
                        w_nxt_ovf     = 1'b1;
                        w_nxt_dom_cnt = '0;
                    end else begin
                        w_nxt_dom_cnt = r_dom_cnt + 1'b1;
                    end
                end else begin
                    // The first recessive bit already belongs to the delimiter.
                    w_nxt_state   = ST_DELIM;
                    w_nxt_bit_cnt = CNT_W'(1);
                end
            end
            ST_DELIM: begin
                if (canRX == RECESSIVE) begin
                    if (r_bit_cnt == DELIM_LAST) begin
                        w_nxt_state   = ST_IDLE;
                        w_nxt_end     = 1'b1;
                        w_nxt_bit_cnt = '0;
                    end else begin
                        w_nxt_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_nxt_bit_err = 1'b1;
                    w_nxt_state   = ST_FLAG;
                    w_nxt_is_err  = 1'b1;
                    w_nxt_passive = errorPassive;
                    w_nxt_tx      = errorPassive ? RECESSIVE : DOMINANT;
                    w_nxt_bit_cnt = '0;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign canTX            = r_tx;
    assign busy             = r_busy;
    assign isErrorFrame     = r_is_err;
    assign endFrame         = r_end;
    assign bitError         = r_bit_err;
    assign dominantOverflow = r_ovf;

endmodule

// File: tb/tb_overload_error_tx.sv
// Bench for overload_error_tx: scenario table, hand-written corner sequences and a
// randomized run against a frame-level reference model.
module tb_overload_error_tx;

    logic clk = 1'b0;
    logic rst, canRX, so, se, ep;
    logic canTX, busy, isErr, endF, bitErr, ovf;

    int errs = 0;
    int checks = 0;

    overload_error_tx dut (
        .samplePoint(clk), .reset(rst), .canRX(canRX),
        .startOverload(so), .startError(se), .errorPassive(ep),
        .canTX(canTX), .busy(busy), .isErrorFrame(isErr),
        .endFrame(endF), .bitError(bitErr), .dominantOverflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic se, so, ep;
        int   dom;        // forced dominant bits right after the flag
        int   exp_end;    // endFrame edge, counted from the start edge
        int   exp_err;
        int   exp_zeros;  // dominant bits driven by the DUT
        int   exp_ovf;
    } scen_t;

    scen_t tbl[6];

    // Start edge = edge 1; canTX after edge c is bit c, sampled by edge c+1.
    task automatic run_scen(input scen_t s, input string nm);
        int end_at = -1, zeros = 0, nov = 0, nbe = 0, ie = -1;
        se = s.se; so = s.so; ep = s.ep; canRX = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            se = 1'b0; so = 1'b0;
            if (c == 1) ie = int'(isErr);
            if (canTX == 1'b0) zeros++;
            nov += int'(ovf);
            nbe += int'(bitErr);
            if (endF) begin
                end_at = c - 1;
                break;
            end
            canRX = (c >= 7 && c <= 6 + s.dom) ? 1'b0 : canTX;
        end
        chk({nm, " end"}, end_at, s.exp_end);
        chk({nm, " isErr"}, ie, s.exp_err);
        chk({nm, " zeros"}, zeros, s.exp_zeros);
        chk({nm, " ovf"}, nov, s.exp_ovf);
        chk({nm, " bitErr"}, nbe, 0);
        chk({nm, " busy_after"}, int'(busy), 0);
        chk({nm, " tx_after"}, int'(canTX), 1);
        canRX = 1'b1;
    endtask

    task automatic drain(input string nm);
        int found = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            se = 1'b0; so = 1'b0;
            if (endF) begin
                found = 1;
                break;
            end
            canRX = canTX;
        end
        chk({nm, " drain_end"}, found, 1);
        canRX = 1'b1;
    endtask

    // Reference model: frame progress as counts of flag bits sent, dominant run, delimiter bits seen.
    logic m_act, m_err, m_pas, m_wait;
    int   m_flag, m_dom, m_delim;
    logic e_end, e_be, e_ovf;

    function automatic void m_reset();
        m_act = 0; m_err = 0; m_pas = 0; m_wait = 0;
        m_flag = 0; m_dom = 0; m_delim = 0;
        e_end = 0; e_be = 0; e_ovf = 0;
    endfunction

    function automatic void m_start(input logic err, input logic pas);
        m_act = 1; m_err = err; m_pas = pas; m_flag = 0; m_wait = 0; m_dom = 0; m_delim = 0;
    endfunction

    function automatic logic m_tx();
        return !(m_act && m_flag < 6 && !m_pas);
    endfunction

    function automatic void m_step(input logic rx, input logic s_e, input logic s_o, input logic p);
        e_end = 0; e_be = 0; e_ovf = 0;
        if (!m_act) begin
            if (s_e) m_start(1, p);
            else if (s_o) m_start(0, 0);
        end else if (m_flag < 6) begin
            if (!m_pas && rx) e_be = 1;
            m_flag++;
            if (m_flag == 6) begin m_wait = 1; m_dom = 0; end
        end else if (m_wait) begin
            if (!rx) begin
                m_dom++;
                if (m_dom % 8 == 0) e_ovf = 1;
            end else begin
                m_wait = 0; m_delim = 1;
            end
        end else if (rx) begin
            m_delim++;
            if (m_delim == 8) begin e_end = 1; m_act = 0; end
        end else begin
            e_be = 1;
            m_start(1, p);
        end
    endfunction

    initial begin
        tbl[0] = '{se:0, so:1, ep:0, dom:0,  exp_end:14, exp_err:0, exp_zeros:6, exp_ovf:0};
        tbl[1] = '{se:1, so:0, ep:0, dom:4,  exp_end:18, exp_err:1, exp_zeros:6, exp_ovf:0};
        tbl[2] = '{se:1, so:0, ep:1, dom:0,  exp_end:14, exp_err:1, exp_zeros:0, exp_ovf:0};
        tbl[3] = '{se:1, so:1, ep:0, dom:0,  exp_end:14, exp_err:1, exp_zeros:6, exp_ovf:0};
        tbl[4] = '{se:1, so:0, ep:0, dom:16, exp_end:30, exp_err:1, exp_zeros:6, exp_ovf:2};
        tbl[5] = '{se:0, so:1, ep:1, dom:8,  exp_end:22, exp_err:0, exp_zeros:6, exp_ovf:1};

        rst = 1'b1; canRX = 1'b1; so = 1'b0; se = 1'b0; ep = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst canTX", int'(canTX), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst isErr", int'(isErr), 0);
        chk("rst pulses", int'({endF, bitErr, ovf}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_scen(tbl[i], $sformatf("scen%0d", i));

        // Request held across the endFrame edge: ignored there, accepted on the next edge.
        so = 1'b1; canRX = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 15) begin
                chk("b2b endFrame", int'(endF), 1);
                chk("b2b busy_low", int'(busy), 0);
            end
            if (c == 16) begin
                chk("b2b restart busy", int'(busy), 1);
                chk("b2b restart tx", int'(canTX), 0);
                chk("b2b restart isErr", int'(isErr), 0);
            end
            so = (c >= 13 && c <= 15);
            canRX = canTX;
        end
        drain("b2b");

        // Dominant at delimiter bit 3 of an overload frame -> active error flag.
        so = 1'b1; ep = 1'b0; canRX = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            so = 1'b0;
            if (c == 9) chk("delim pre bitErr", int'(bitErr), 0);
            if (c == 10) begin
                chk("delim bitErr", int'(bitErr), 1);
                chk("delim new flag tx", int'(canTX), 0);
                chk("delim isErr", int'(isErr), 1);
                chk("delim endFrame", int'(endF), 0);
            end
            canRX = (c == 9) ? 1'b0 : canTX;
        end
        drain("delim_err");

        // Recessive seen during an active flag bit: pulse, flag continues.
        se = 1'b1; ep = 1'b0; canRX = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            se = 1'b0;
            if (c == 3) begin
                chk("flag bitErr", int'(bitErr), 1);
                chk("flag tx held", int'(canTX), 0);
            end
            if (c == 4) chk("flag bitErr one", int'(bitErr), 0);
            canRX = (c == 2) ? 1'b1 : canTX;
        end
        drain("flag_err");

        // Asynchronous reset in the middle of the flag.
        so = 1'b1; canRX = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            so = 1'b0;
            canRX = canTX;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst canTX", int'(canTX), 1);
        chk("midrst busy", int'(busy), 0);
        rst = 1'b0; canRX = 1'b1;
        run_scen(tbl[0], "after_rst");

        // Randomized run against the model.
        begin
            int burst = 0;
            logic rx;
            rst = 1'b1; #1 rst = 1'b0;
            m_reset();
            for (int n = 0; n < 3000; n++) begin
                se = ($urandom % 20 == 0);
                so = ($urandom % 12 == 0);
                ep = $urandom % 2;
                if (burst > 0) begin
                    rx = 1'b0; burst--;
                end else if ($urandom % 40 == 0) begin
                    burst = $urandom_range(1, 20); rx = 1'b0;
                end else if ($urandom % 30 == 0) begin
                    rx = 1'b1;
                end else begin
                    rx = m_tx() & ($urandom % 10 != 0);
                end
                canRX = rx;
                @(posedge clk); #1;
                m_step(rx, se, so, ep);
                chk($sformatf("rand%0d outs", n),
                    int'({canTX, busy, isErr, endF, bitErr, ovf}),
                    int'({m_tx(), m_act, m_err, e_end, e_be, e_ovf}));
                if ($urandom % 400 == 0) begin
                    #2 rst = 1'b1;
                    #1 rst = 1'b0;
                    m_reset();
                    burst = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
